gray_seq_lookup: RTL and testbench
==================================

// Module: gray_seq_lookup
// PURPOSE
//   Sequential, handshaked successor to the combinational key-lookup mux.
//   - LOOKUP mode: accepts a key, searches an NR-entry key/data table one entry per
//     cycle and returns the first match, or DEF on a miss.
//   - SCAN mode: streams every table entry out in Gray-code index order.
//   Sits between a table producer (config regs / decoder) and a consumer that can
//   apply backpressure.
// PARAMETERS
//   NR  4  table entries; power of 2, >=2
//   KW  2  key width
//   DW  8  data width
//   IW  derived localparam, $clog2(NR), entry index width
// PORTS
//   clk        in   1      clock; all state on rising edge
//   rst        in   1      reset, synchronous, active-high
//   req_valid  in   1      request valid
//   req_ready  out  1      request ready; 1 only in IDLE and rst low
//   req_mode   in   1      0=LOOKUP, 1=SCAN; latched at accept
//   req_sel    in   KW     lookup key; latched at accept; value 0 reserved
//   def        in   DW     miss/reserved data; latched at accept
//   keys       in   NR*KW  entry i key = keys[KW*i +: KW]; key 0 = entry disabled
//   datas      in   NR*DW  entry i data = datas[DW*i +: DW]
//   rsp_valid  out  1      response valid
//   rsp_ready  in   1      response ready
//   rsp_data   out  DW     response data
//   rsp_hit    out  1      LOOKUP: match found; SCAN: entry key != 0
//   rsp_idx    out  IW     entry index (0 on miss/reserved)
//   rsp_last   out  1      final beat of transaction (always 1 in LOOKUP)
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Reset: rst high at an edge -> state IDLE; rsp_valid, rsp_data, rsp_hit, rsp_idx,
//     rsp_last and busy all 0.
//   - req_ready=0 while rst is high.
//   - Reset mid-transaction aborts it; no response is emitted.
//   States: IDLE, SEARCH, SCAN, RESP. Accept = req_valid & req_ready at edge T.
//   IDLE -> SEARCH: LOOKUP with req_sel != 0.
//   IDLE -> RESP: LOOKUP with req_sel == 0. Response rsp_valid at T+1 with def,
//     hit=0, idx=0.
//   SEARCH: binary index i=0..NR-1; entry i compared in cycle T+1+i.
//     - Match = keys[i]==sel and keys[i]!=0. Lowest index wins.
//     - Match at i -> RESP at T+2+i: data=datas[i], hit=1, idx=i.
//     - No match after i=NR-1 -> RESP at T+1+NR: def, hit=0, idx=0.
//   IDLE -> SCAN -> RESP: step counter s=0..NR-1, entry e=s^(s>>1) over IW bits.
//     - First beat rsp_valid at T+1.
//     - NR=4 order: 0,1,3,2.
//   RESP: rsp_* registered and held stable while rsp_valid & !rsp_ready.
//     - LOOKUP: on handshake -> IDLE; rsp_last=1.
//     - SCAN: on handshake of a non-last beat, the next beat is presented the next
//       cycle (one beat per cycle when rsp_ready held high).
//     - SCAN: rsp_last=1 on s==NR-1; its handshake -> IDLE.
//   keys/datas are sampled live; the driver holds them stable while busy=1.
//   Response handshake and new request never overlap: req_ready=0 in RESP. A new
//     request is accepted at the earliest one cycle after the final handshake.
//   req_sel, def and keys compare at full KW/DW width; no truncation or extension.
// TESTING (NR=4 KW=2 DW=8)
//   1 Reset: rst=1 for 2 cycles in the middle of a SCAN
//       -> all rsp_* and busy = 0, no further beats;
//       -> req_ready=1 in the first cycle after rst drops.
//   2 Lookup hit: keys={e3:2,e2:3,e1:2,e0:1}, datas={D3,C2,B1,A0}, sel=2 accepted at T
//       -> rsp_valid at T+3: data=B1, hit=1, idx=1, last=1 (first match beats e3).
//   3 Lookup miss: keys all 1, sel=3, def=EE accepted at T
//       -> rsp_valid at T+5: data=EE, hit=0, idx=0.
//   4 Reserved key: sel=0, def=5A accepted at T; table also has a key-0 entry
//       -> rsp_valid at T+1: data=5A, hit=0; no SEARCH cycles.
//   5 Scan with backpressure: mode=1, rsp_ready low 3 cycles on beat 2
//       -> idx sequence 0,1,3,2; beat 2 held stable while stalled;
//       -> last=1 only on idx 2; busy=0 after the final handshake.
//   6 Back-to-back: req_valid held high across transactions
//       -> the second request is accepted exactly one cycle after the first
//          transaction's final rsp handshake.

Source files
------------

// File: rtl/gray_seq_lookup.sv
// gray_seq_lookup: handshaked key/data table engine.
// LOOKUP walks the table one entry per cycle and returns the lowest-index match,
// or the latched default on a miss or reserved key. SCAN streams every entry in
// Gray-code index order, one beat per accepted response.
module gray_seq_lookup #(
    parameter  int NR = 4,
    parameter  int KW = 2,
    parameter  int DW = 8,
    localparam int IW = $clog2(NR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_mode,
    input  logic [KW-1:0]      req_sel,
    input  logic [DW-1:0]      def,
    input  logic [NR*KW-1:0]   keys,
    input  logic [NR*DW-1:0]   datas,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_hit,
    output logic [IW-1:0]      rsp_idx,
    output logic               rsp_last,
    output logic               busy
);

    // SCAN presents non-final beats; RESP presents the final beat of any transaction.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_SCAN   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [IW-1:0] LAST_STEP = IW'(NR - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   step_q, step_d;
    logic [KW-1:0]   sel_q, sel_d;
    logic [DW-1:0]   def_q, def_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_hit_q, rsp_hit_d;
    logic [IW-1:0]   rsp_idx_q, rsp_idx_d;
    logic            rsp_last_q, rsp_last_d;
    logic            busy_q, busy_d;

    logic            req_accept_s;
    logic            rsp_fire_s;
    logic [IW-1:0]   cur_entry_s;
    logic [KW-1:0]   cur_key_s;

    function automatic logic [IW-1:0] gray_of(input logic [IW-1:0] s);
        return s ^ (s >> 1);
    endfunction

    function automatic logic [KW-1:0] key_at(input logic [IW-1:0] i);
        return keys[KW*i +: KW];
    endfunction

    function automatic logic [DW-1:0] data_at(input logic [IW-1:0] i);
        return datas[DW*i +: DW];
    endfunction

    assign req_ready    = (state_q == ST_IDLE) && !rst;
    assign req_accept_s = req_valid && req_ready;
    assign rsp_fire_s   = rsp_valid_q && rsp_ready;
    assign cur_key_s    = key_at(step_q);

    // Next-state and next-response computation for every state.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        sel_d       = sel_q;
        def_d       = def_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_last_d  = rsp_last_q;
        cur_entry_s = {IW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (req_accept_s) begin
                    sel_d  = req_sel;
                    def_d  = def;
                    step_d = {IW{1'b0}};
                    if (req_mode) begin
                        // First scan beat is registered at accept.
                        cur_entry_s = gray_of({IW{1'b0}});
                        state_d     = ST_SCAN;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = data_at(cur_entry_s);
                        rsp_hit_d   = (key_at(cur_entry_s) != {KW{1'b0}});
                        rsp_idx_d   = cur_entry_s;
                        rsp_last_d  = 1'b0;
                    end else if (req_sel == {KW{1'b0}}) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = def;
                        rsp_hit_d   = 1'b0;
                        rsp_idx_d   = {IW{1'b0}};
                        rsp_last_d  = 1'b1;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if ((cur_key_s == sel_q) && (cur_key_s != {KW{1'b0}})) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = data_at(step_q);
                    rsp_hit_d   = 1'b1;
                    rsp_idx_d   = step_q;
                    rsp_last_d  = 1'b1;
                end else if (step_q == LAST_STEP) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = def_q;
                    rsp_hit_d   = 1'b0;
                    rsp_idx_d   = {IW{1'b0}};
                    rsp_last_d  = 1'b1;
                end else begin
                    step_d = step_q + IW'(1);
                end
            end
            ST_SCAN: begin
                if (rsp_fire_s) begin
                    // Advance to the next Gray-ordered entry once the current beat is taken.
                    step_d      = step_q + IW'(1);
                    cur_entry_s = gray_of(step_d);
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = data_at(cur_entry_s);
                    rsp_hit_d   = (key_at(cur_entry_s) != {KW{1'b0}});
                    rsp_idx_d   = cur_entry_s;
                    rsp_last_d  = (step_d == LAST_STEP);
                    state_d     = (step_d == LAST_STEP) ? ST_RESP : ST_SCAN;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_RESP: begin
                if (rsp_fire_s) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // All state and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= {IW{1'b0}};
            sel_q       <= {KW{1'b0}};
            def_q       <= {DW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DW{1'b0}};
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= {IW{1'b0}};
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            sel_q       <= sel_d;
            def_q       <= def_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_last_q  <= rsp_last_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gray_seq_lookup.sv
// Bench for gray_seq_lookup (NR=4 KW=2 DW=8): a transaction-level model predicts
// beats and their latency; a negedge process compares every cycle, and directed
// tests add hand-computed literal expectations.
module tb_gray_seq_lookup;

    localparam int NR = 4;
    localparam int KW = 2;
    localparam int DW = 8;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_mode = 1'b0;
    logic [KW-1:0]    req_sel = '0;
    logic [DW-1:0]    def = '0;
    logic [NR*KW-1:0] keys = '0;
    logic [NR*DW-1:0] datas = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [DW-1:0]    rsp_data;
    logic             rsp_hit;
    logic [IW-1:0]    rsp_idx;
    logic             rsp_last;
    logic             busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    gray_seq_lookup #(.NR(NR), .KW(KW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_sel(req_sel), .def(def), .keys(keys), .datas(datas),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_hit(rsp_hit), .rsp_idx(rsp_idx), .rsp_last(rsp_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic          hit;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t beats[$];
    beat_t m_cur;
    bit    m_busy = 1'b0;
    bit    m_valid = 1'b0;
    int    m_lat = 0;

    function automatic logic [KW-1:0] tkey(input int i);
        logic [NR*KW-1:0] k;
        k = keys;
        return k[KW*i +: KW];
    endfunction

    function automatic logic [DW-1:0] tdata(input int i);
        logic [NR*DW-1:0] d;
        d = datas;
        return d[DW*i +: DW];
    endfunction

    // Build the expected beats of an accepted request and how many edges until the first is visible.
    task automatic model_accept();
        int order[4] = '{0, 1, 3, 2};
        int hit_at;
        beat_t b;
        beats.delete();
        if (req_mode) begin
            for (int s = 0; s < NR; s++) begin
                b.data = tdata(order[s]);
                b.hit  = (tkey(order[s]) != 0);
                b.idx  = IW'(order[s]);
                b.last = (s == NR - 1);
                beats.push_back(b);
            end
            m_lat = 0;
        end else begin
            hit_at = -1;
            if (req_sel != 0) begin
                for (int i = NR - 1; i >= 0; i--)
                    if (tkey(i) == req_sel) hit_at = i;
            end
            b.last = 1'b1;
            if (req_sel == 0) begin
                b.data = def; b.hit = 1'b0; b.idx = '0; m_lat = 0;
            end else if (hit_at >= 0) begin
                b.data = tdata(hit_at); b.hit = 1'b1; b.idx = IW'(hit_at); m_lat = hit_at + 1;
            end else begin
                b.data = def; b.hit = 1'b0; b.idx = '0; m_lat = NR;
            end
            beats.push_back(b);
        end
    endtask

    // Advance the model on each rising edge using the inputs present at that edge.
    always @(posedge clk) begin
        if (rst) begin
            beats.delete();
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_lat   = 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                model_accept();
                m_busy = 1'b1;
                if (m_lat == 0) begin
                    m_valid = 1'b1;
                    m_cur   = beats[0];
                end
            end
        end else if (m_valid) begin
            if (rsp_ready) begin
                void'(beats.pop_front());
                if (beats.size() == 0) begin
                    m_valid = 1'b0;
                    m_busy  = 1'b0;
                end else begin
                    m_cur = beats[0];
                end
            end
        end else begin
            m_lat--;
            if (m_lat == 0) begin
                m_valid = 1'b1;
                m_cur   = beats[0];
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_req_ready", 32'(req_ready), 32'(!m_busy && !rst));
            if (m_valid) begin
                chk("model_rsp_data", 32'(rsp_data), 32'(m_cur.data));
                chk("model_rsp_hit", 32'(rsp_hit), 32'(m_cur.hit));
                chk("model_rsp_idx", 32'(rsp_idx), 32'(m_cur.idx));
                chk("model_rsp_last", 32'(rsp_last), 32'(m_cur.last));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a LOOKUP, measure edges to rsp_valid, check the response, then take it.
    task automatic do_lookup(input string nm, input logic [KW-1:0] sel, input logic [DW-1:0] dflt,
                             input int exp_lat, input logic [DW-1:0] exp_data,
                             input logic exp_hit, input logic [IW-1:0] exp_idx);
        int n;
        req_valid = 1'b1; req_mode = 1'b0; req_sel = sel; def = dflt;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
        chk({nm, "_data"}, 32'(rsp_data), 32'(exp_data));
        chk({nm, "_hit"}, 32'(rsp_hit), 32'(exp_hit));
        chk({nm, "_idx"}, 32'(rsp_idx), 32'(exp_idx));
        chk({nm, "_last"}, 32'(rsp_last), 32'd1);
        tick();
        chk({nm, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int hs;
        int stall;
        int got_idx[4];
        int got_last[4];
        int got_hit[4];

        // Power-up reset
        rst = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_ready_in_rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_req_ready_after", 32'(req_ready), 32'd1);
        tick();

        // Test 1: reset in the middle of a stalled SCAN
        keys = {2'd3, 2'd2, 2'd1, 2'd3};
        datas = {8'h44, 8'h33, 8'h22, 8'h11};
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_mode = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("t1_scan_started", 32'(rsp_valid), 32'd1);
        tick();
        rst = 1'b1;
        tick(); tick();
        chk("t1_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        chk("t1_rst_hit_idx_last", 32'({rsp_hit, rsp_idx, rsp_last}), 32'd0);
        chk("t1_rst_data", 32'(rsp_data), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("t1_req_ready_after_rst", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_no_beats", 32'(rsp_valid), 32'd0);
        end

        // Test 2: lookup hit, first match wins
        keys = {2'd2, 2'd3, 2'd2, 2'd1};
        datas = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        do_lookup("t2_hit", 2'd2, 8'h00, 3, 8'hB1, 1'b1, 2'd1);
        do_lookup("t2_hit_e3side", 2'd3, 8'h00, 4, 8'hC2, 1'b1, 2'd2);

        // Test 3: lookup miss
        keys = 8'h55;
        do_lookup("t3_miss", 2'd3, 8'hEE, 5, 8'hEE, 1'b0, 2'd0);

        // Test 4: reserved key with a disabled entry present
        keys = {2'd1, 2'd2, 2'd0, 2'd3};
        do_lookup("t4_reserved", 2'd0, 8'h5A, 1, 8'h5A, 1'b0, 2'd0);

        // Test 5: scan with backpressure on beat 2
        keys = {2'd0, 2'd3, 2'd2, 2'd1};
        datas = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req_valid = 1'b1; req_mode = 1'b1;
        tick();
        req_valid = 1'b0;
        hs = 0; stall = 0;
        for (int c = 0; c < 30 && hs < 4; c++) begin
            if (rsp_valid && hs == 2 && stall < 3) begin
                rsp_ready = 1'b0;
                stall++;
                chk("t5_stall_data", 32'(rsp_data), 32'hD3);
                chk("t5_stall_idx", 32'(rsp_idx), 32'd3);
            end else begin
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    got_idx[hs]  = int'(rsp_idx);
                    got_last[hs] = int'(rsp_last);
                    got_hit[hs]  = int'(rsp_hit);
                    hs++;
                end
            end
            tick();
        end
        rsp_ready = 1'b1;
        chk("t5_beat_count", 32'(hs), 32'd4);
        chk("t5_idx_seq", {got_idx[0][7:0], got_idx[1][7:0], got_idx[2][7:0], got_idx[3][7:0]},
            32'h00010302);
        chk("t5_last_seq", {got_last[0][7:0], got_last[1][7:0], got_last[2][7:0], got_last[3][7:0]},
            32'h00000001);
        chk("t5_hit_seq", {got_hit[0][7:0], got_hit[1][7:0], got_hit[2][7:0], got_hit[3][7:0]},
            32'h01010001);
        chk("t5_busy_after", 32'(busy), 32'd0);

        // Test 6: back-to-back requests with req_valid held high
        req_valid = 1'b1; req_mode = 1'b0; req_sel = 2'd0; def = 8'h77;
        tick();
        chk("t6_first_rsp", 32'(rsp_valid), 32'd1);
        chk("t6_not_ready_in_resp", 32'(req_ready), 32'd0);
        tick();
        chk("t6_idle_gap", 32'({busy, rsp_valid}), 32'd0);
        chk("t6_ready_gap", 32'(req_ready), 32'd1);
        def = 8'h78;
        tick();
        req_valid = 1'b0;
        chk("t6_second_accepted", 32'(busy), 32'd1);
        chk("t6_second_data", 32'(rsp_data), 32'h78);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
